// File: rtl/execute_stage_if.sv
// execute_stage_if: bundles the instruction inputs and memory-stage outputs of execute_stage.
//   slave  modport - the execute stage (consumes instruction fields, drives results and stall)
//   master modport - the upstream/downstream environment (drives instruction, observes results)
//   Fields: valid_in, opcode, operand_a, operand_b, imm, dest_reg, flush -> stage
//           stall, result_out, reg_addr_out, write_enable_out, mem_addr_out,
//           store_enable_out, load_enable_out, carry_out, zero_out <- stage
interface execute_stage_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4
);
    logic              valid_in;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [7:0]        imm;
    logic [REG_AW-1:0] dest_reg;
    logic              flush;
    logic              stall;
    logic [DATA_W-1:0] result_out;
    logic [REG_AW-1:0] reg_addr_out;
    logic              write_enable_out;
    logic [REG_AW-1:0] mem_addr_out;
    logic              store_enable_out;
    logic              load_enable_out;
    logic              carry_out;
    logic              zero_out;

    modport slave (
        input  valid_in, opcode, operand_a, operand_b, imm, dest_reg, flush,
        output stall, result_out, reg_addr_out, write_enable_out, mem_addr_out,
               store_enable_out, load_enable_out, carry_out, zero_out
    );

    modport master (
        output valid_in, opcode, operand_a, operand_b, imm, dest_reg, flush,
        input  stall, result_out, reg_addr_out, write_enable_out, mem_addr_out,
               store_enable_out, load_enable_out, carry_out, zero_out
    );
endinterface

// File: rtl/execute_stage.sv
// execute_stage: execute stage of the 16-bit pipelined RISC CPU.
//   ALU ops, load/store address generation and a 16-step shift-add multiplier.
//   Ports:
//     clk     - clock, rising edge
//     reset_n - synchronous active-low reset
//     bus     - execute_stage_if.slave: instruction in, registered memory-stage outputs,
//               combinational stall back to upstream
module execute_stage #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned REG_AW    = 4,
    parameter int unsigned MUL_STEPS = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    execute_stage_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(MUL_STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4, OP_SHL = 4'd5, OP_SHR = 4'd6, OP_MUL = 4'd7;
    localparam logic [3:0] OP_LOAD = 4'd8, OP_STORE = 4'd9, OP_LI = 4'd10;

    typedef enum logic [1:0] {StIdle, StMulBusy, StMulDone} state_e;

    state_e            r_state, w_state;
    logic [CNT_W-1:0]  r_count, w_count;
    logic [DATA_W-1:0] r_mcand, w_mcand, r_mplier, w_mplier, r_acc, w_acc;
    logic [DATA_W-1:0] r_result, w_result;
    logic [REG_AW-1:0] r_reg_addr, w_reg_addr, r_mem_addr, w_mem_addr;
    logic              r_we, w_we, r_store, w_store, r_load, w_load;
    logic              r_carry, w_carry, r_zero, w_zero;

    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_diff, w_alu;
    logic [REG_AW-1:0] w_addr;
    logic              w_mul_start;

    assign w_sum  = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
    assign w_diff = bus.operand_a - bus.operand_b;
    assign w_addr = bus.operand_a[REG_AW-1:0] + bus.imm[REG_AW-1:0];

    always_comb begin
        w_alu = '0;
        case (bus.opcode)
            OP_ADD:  w_alu = w_sum[DATA_W-1:0];
            OP_SUB:  w_alu = w_diff;
            OP_AND:  w_alu = bus.operand_a & bus.operand_b;
            OP_OR:   w_alu = bus.operand_a | bus.operand_b;
            OP_XOR:  w_alu = bus.operand_a ^ bus.operand_b;
            OP_SHL:  w_alu = bus.operand_a << bus.operand_b[3:0];
            OP_SHR:  w_alu = bus.operand_a >> bus.operand_b[3:0];
            OP_LI:   w_alu = {{(DATA_W-8){1'b0}}, bus.imm};
            default: w_alu = '0;
        endcase
    end

    // A MUL presented in IDLE stalls immediately, before the FSM has left IDLE.
    assign w_mul_start = (r_state == StIdle) && bus.valid_in && (bus.opcode == OP_MUL);
    assign bus.stall   = reset_n && ((r_state == StMulBusy) || w_mul_start);

    always_comb begin
        w_state    = r_state;
        w_count    = r_count;
        w_mcand    = r_mcand;
        w_mplier   = r_mplier;
        w_acc      = r_acc;
        w_carry    = r_carry;
        w_zero     = r_zero;
        // Bubble by default; only issuing paths override these.
        w_result   = '0;
        w_reg_addr = '0;
        w_mem_addr = '0;
        w_we       = 1'b0;
        w_store    = 1'b0;
        w_load     = 1'b0;

        if (bus.flush) begin
            w_state = StIdle;
            w_count = '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.valid_in) begin
                        case (bus.opcode)
                            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_LI: begin
                                w_result   = w_alu;
                                w_reg_addr = bus.dest_reg;
                                w_we       = 1'b1;
                                w_zero     = (w_alu == '0);
                                if (bus.opcode == OP_ADD) w_carry = w_sum[DATA_W];
                                if (bus.opcode == OP_SUB) w_carry = bus.operand_a < bus.operand_b;
                            end
                            OP_MUL: begin
                                w_mcand  = bus.operand_a;
                                w_mplier = bus.operand_b;
                                w_acc    = '0;
                                w_count  = '0;
                                w_state  = StMulBusy;
                            end
                            OP_LOAD: begin
                                w_mem_addr = w_addr;
                                w_load     = 1'b1;
                                w_we       = 1'b1;
                                w_reg_addr = bus.dest_reg;
                            end
                            OP_STORE: begin
                                w_mem_addr = w_addr;
                                w_store    = 1'b1;
                                w_result   = bus.operand_b;
                                w_reg_addr = bus.dest_reg;
                            end
                            default: ;
                        endcase
                    end
                end
                StMulBusy: begin
                    if (r_mplier[0]) w_acc = r_acc + r_mcand;
                    w_mcand  = r_mcand << 1;
                    w_mplier = r_mplier >> 1;
                    w_count  = r_count + 1'b1;
                    if (r_count == LAST_STEP) w_state = StMulDone;
                end
                StMulDone: begin
                    // The MUL is still held on the inputs; retire it and return to IDLE.
                    w_result   = r_acc;
                    w_reg_addr = bus.dest_reg;
                    w_we       = 1'b1;
                    w_zero     = (r_acc == '0);
                    w_state    = StIdle;
                    w_count    = '0;
                end
                default: begin
                    w_state = StIdle;
                    w_count = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_count    <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_result   <= '0;
            r_reg_addr <= '0;
            r_mem_addr <= '0;
            r_we       <= 1'b0;
            r_store    <= 1'b0;
            r_load     <= 1'b0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_count    <= w_count;
            r_mcand    <= w_mcand;
            r_mplier   <= w_mplier;
            r_acc      <= w_acc;
            r_result   <= w_result;
            r_reg_addr <= w_reg_addr;
            r_mem_addr <= w_mem_addr;
            r_we       <= w_we;
            r_store    <= w_store;
            r_load     <= w_load;
            r_carry    <= w_carry;
            r_zero     <= w_zero;
        end
    end

    assign bus.result_out       = r_result;
    assign bus.reg_addr_out     = r_reg_addr;
    assign bus.write_enable_out = r_we;
    assign bus.mem_addr_out     = r_mem_addr;
    assign bus.store_enable_out = r_store;
    assign bus.load_enable_out  = r_load;
    assign bus.carry_out        = r_carry;
    assign bus.zero_out         = r_zero;
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed and random stimulus for execute_stage, checked against an
// arithmetic reference model of the instruction set.
module tb_execute_stage;
    logic clk = 1'b0;
    logic reset_n;
    int   n_assert = 0;
    int   n_fail   = 0;
    bit   m_carry  = 1'b0;
    bit   m_zero   = 1'b0;

    always #5 clk = ~clk;

    execute_stage_if bus ();

    execute_stage dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_we"},     32'(bus.write_enable_out), 0);
        check({tag, "_store"},  32'(bus.store_enable_out), 0);
        check({tag, "_load"},   32'(bus.load_enable_out), 0);
        check({tag, "_result"}, 32'(bus.result_out), 0);
        check({tag, "_reg"},    32'(bus.reg_addr_out), 0);
        check({tag, "_mem"},    32'(bus.mem_addr_out), 0);
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] im, input logic [3:0] d);
        bus.valid_in  = 1'b1;
        bus.opcode    = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.imm       = im;
        bus.dest_reg  = d;
    endtask

    // Present one instruction (held through any stall) and check what it issues.
    task automatic exec(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] im, input logic [3:0] d);
        int     ia, ib, s, res, maddr, rd, nstall;
        bit     we, st, ld;
        longint prod;
        ia = int'(a); ib = int'(b);
        res = 0; maddr = 0; rd = 0; we = 0; st = 0; ld = 0;
        case (op)
            4'd0: begin s = ia + ib; res = s % 65536; m_carry = (s > 65535); end
            4'd1: begin res = (ia - ib + 65536) % 65536; m_carry = (ia < ib); end
            4'd2: res = int'(a & b);
            4'd3: res = int'(a | b);
            4'd4: res = int'(a ^ b);
            4'd5: res = (ia * (1 << (ib % 16))) % 65536;
            4'd6: res = ia / (1 << (ib % 16));
            4'd7: begin prod = longint'(ia) * longint'(ib); res = int'(prod % 65536); end
            4'd10: res = int'(im);
            default: ;
        endcase
        if (op <= 4'd7 || op == 4'd10) begin
            we = 1; rd = int'(d); m_zero = (res == 0);
        end
        if (op == 4'd8) begin
            maddr = (ia % 16 + int'(im) % 16) % 16; ld = 1; we = 1; rd = int'(d); res = 0;
        end
        if (op == 4'd9) begin
            maddr = (ia % 16 + int'(im) % 16) % 16; st = 1; rd = int'(d); res = ib;
        end

        drive(op, a, b, im, d);
        #1;
        check("stall_at_present", 32'(bus.stall), 32'(op == 4'd7));
        nstall = 0;
        while (bus.stall && nstall < 40) begin
            @(posedge clk); #1;
            nstall++;
            check_bubble("mul_busy");
        end
        check("stall_cycles", nstall, (op == 4'd7) ? 17 : 0);
        @(posedge clk); #1;
        check("result",   32'(bus.result_out), res);
        check("reg_addr", 32'(bus.reg_addr_out), rd);
        check("we",       32'(bus.write_enable_out), 32'(we));
        check("mem_addr", 32'(bus.mem_addr_out), maddr);
        check("store",    32'(bus.store_enable_out), 32'(st));
        check("load",     32'(bus.load_enable_out), 32'(ld));
        check("carry",    32'(bus.carry_out), 32'(m_carry));
        check("zero",     32'(bus.zero_out), 32'(m_zero));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n   = 1'b0;
        bus.flush = 1'b0;
        drive(4'd0, 16'h1234, 16'h1111, 8'h00, 4'd2);
        repeat (2) @(posedge clk);
        #1;
        check_bubble("reset");
        check("reset_stall", 32'(bus.stall), 0);
        check("reset_carry", 32'(bus.carry_out), 0);
        check("reset_zero",  32'(bus.zero_out), 0);
        bus.valid_in = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;

        exec(4'd0, 16'hFFFF, 16'h0001, 8'h00, 4'd3);
        exec(4'd1, 16'h0005, 16'h0007, 8'h00, 4'd1);
        exec(4'd5, 16'h0001, 16'h0013, 8'h00, 4'd2);
        exec(4'd9, 16'h000E, 16'hBEEF, 8'h03, 4'd4);
        exec(4'd8, 16'h0002, 16'h0000, 8'h04, 4'd5);
        exec(4'd10, 16'h0000, 16'h0000, 8'hA5, 4'd6);
        exec(4'd7, 16'h0123, 16'h0045, 8'h00, 4'd7);
        exec(4'd0, 16'h0010, 16'h0020, 8'h00, 4'd8);
        exec(4'd12, 16'h1111, 16'h2222, 8'h00, 4'd9);

        // Flush in the 5th busy cycle of a multiply.
        drive(4'd7, 16'h00FF, 16'h0100, 8'h00, 4'd10);
        #1;
        check("flush_stall_pre", 32'(bus.stall), 1);
        repeat (5) begin @(posedge clk); #1; end
        check("flush_stall_busy", 32'(bus.stall), 1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.valid_in = 1'b0;
        #1;
        check_bubble("flush");
        check("flush_stall_after", 32'(bus.stall), 0);
        check("flush_carry", 32'(bus.carry_out), 32'(m_carry));
        check("flush_zero",  32'(bus.zero_out), 32'(m_zero));
        exec(4'd0, 16'h0003, 16'h0004, 8'h00, 4'd11);

        // Reset in the 5th busy cycle of a multiply, MUL still on the inputs.
        drive(4'd7, 16'h00FF, 16'h0100, 8'h00, 4'd10);
        repeat (5) begin @(posedge clk); #1; end
        check("rst_stall_busy", 32'(bus.stall), 1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        m_carry = 1'b0;
        m_zero  = 1'b0;
        check_bubble("midrst");
        check("midrst_stall", 32'(bus.stall), 0);
        check("midrst_carry", 32'(bus.carry_out), 0);
        check("midrst_zero",  32'(bus.zero_out), 0);
        bus.valid_in = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_bubble("post_rst_idle");
        exec(4'd0, 16'h8000, 16'h8000, 8'h00, 4'd12);

        for (int i = 0; i < 40; i++) begin
            exec(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
                 8'($urandom), 4'($urandom));
        end
        bus.valid_in = 1'b0;
        @(posedge clk); #1;
        check_bubble("final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
